// File: rtl/final_pcpi_accel.sv
// PCPI custom-0 coprocessor: RGB->gray conversion and word sum over a private memory port.
// Latency 8*NUM_PIXELS+2 (GRAY) / 2*rs2+2 (SUM) cycles; stalls on mem_ready, holds pcpi_wait while busy.
module final_pcpi_accel #(
  parameter int NUM_PIXELS = 14400
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] NPIX = 32'(NUM_PIXELS);

  typedef enum logic [2:0] {
    IDLE, RD_R, RD_G, RD_B, WR, SUM_RD, RESP, COOL
  } state_t;

  state_t      state_q;
  logic [31:0] rs2_q, src_q, dst_q, idx_q, acc_q;
  logic [7:0]  r_q, g_q;
  logic        pcpi_wr_q, pcpi_wait_q, pcpi_ready_q;
  logic [31:0] pcpi_rd_q;
  logic        mem_valid_q, mem_write_q;
  logic [31:0] mem_addr_q, mem_wdata_q;

  logic        insn_match, is_sum, mem_done;
  logic [31:0] idx_d, acc_d;
  logic [15:0] gray_sum_d;
  logic [7:0]  gray_d;
  logic        unused_bits;

  assign insn_match = (pcpi_insn[6:0] == 7'b0001011) && (pcpi_insn[31:25] == 7'd0) &&
                      (pcpi_insn[14:13] == 2'b00);
  assign is_sum     = pcpi_insn[12];
  // The request cycle itself never completes an access, so every access takes >= 2 cycles.
  assign mem_done   = !mem_valid_q && mem_ready;
  assign idx_d      = idx_q + 32'd1;
  assign acc_d      = acc_q + mem_rdata;
  assign gray_sum_d = 16'd77 * {8'd0, r_q} + 16'd150 * {8'd0, g_q} + 16'd29 * {8'd0, mem_rdata[7:0]};
  assign gray_d     = gray_sum_d[15:8];
  assign unused_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7], gray_sum_d[7:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      rs2_q        <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      r_q          <= '0;
      g_q          <= '0;
      pcpi_wr_q    <= 1'b0;
      pcpi_rd_q    <= '0;
      pcpi_wait_q  <= 1'b0;
      pcpi_ready_q <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      mem_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pcpi_valid && insn_match) begin
            rs2_q <= pcpi_rs2;
            src_q <= pcpi_rs1;
            dst_q <= pcpi_rs2;
            idx_q <= '0;
            acc_q <= '0;
            if ((is_sum && pcpi_rs2 == 32'd0) || (!is_sum && NPIX == 32'd0)) begin
              state_q      <= RESP;
              pcpi_ready_q <= 1'b1;
              pcpi_wr_q    <= 1'b1;
              pcpi_rd_q    <= is_sum ? 32'd0 : NPIX;
            end else begin
              state_q     <= is_sum ? SUM_RD : RD_R;
              pcpi_wait_q <= 1'b1;
              mem_valid_q <= 1'b1;
              mem_write_q <= 1'b0;
              mem_addr_q  <= pcpi_rs1;
            end
          end
        end
        RD_R: begin
          if (mem_done) begin
            r_q         <= mem_rdata[7:0];
            mem_valid_q <= 1'b1;
            mem_addr_q  <= src_q + 32'd4;
            state_q     <= RD_G;
          end
        end
        RD_G: begin
          if (mem_done) begin
            g_q         <= mem_rdata[7:0];
            mem_valid_q <= 1'b1;
            mem_addr_q  <= src_q + 32'd8;
            state_q     <= RD_B;
          end
        end
        RD_B: begin
          if (mem_done) begin
            mem_valid_q <= 1'b1;
            mem_write_q <= 1'b1;
            mem_addr_q  <= dst_q;
            mem_wdata_q <= {24'd0, gray_d};
            state_q     <= WR;
          end
        end
        WR: begin
          if (mem_done) begin
            mem_write_q <= 1'b0;
            if (idx_d < NPIX) begin
              idx_q       <= idx_d;
              src_q       <= src_q + 32'd12;
              dst_q       <= dst_q + 32'd4;
              mem_valid_q <= 1'b1;
              mem_addr_q  <= src_q + 32'd12;
              state_q     <= RD_R;
            end else begin
              state_q      <= RESP;
              pcpi_wait_q  <= 1'b0;
              pcpi_ready_q <= 1'b1;
              pcpi_wr_q    <= 1'b1;
              pcpi_rd_q    <= NPIX;
            end
          end
        end
        SUM_RD: begin
          if (mem_done) begin
            acc_q <= acc_d;
            if (idx_d < rs2_q) begin
              idx_q       <= idx_d;
              src_q       <= src_q + 32'd4;
              mem_valid_q <= 1'b1;
              mem_addr_q  <= src_q + 32'd4;
            end else begin
              state_q      <= RESP;
              pcpi_wait_q  <= 1'b0;
              pcpi_ready_q <= 1'b1;
              pcpi_wr_q    <= 1'b1;
              pcpi_rd_q    <= acc_d;
            end
          end
        end
        RESP: begin
          pcpi_ready_q <= 1'b0;
          pcpi_wr_q    <= 1'b0;
          state_q      <= COOL;
        end
        // The core still holds pcpi_valid here; skipping one cycle avoids re-accepting it.
        COOL: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pcpi_wr    = pcpi_wr_q;
  assign pcpi_rd    = pcpi_rd_q;
  assign pcpi_wait  = pcpi_wait_q;
  assign pcpi_ready = pcpi_ready_q;
  assign mem_valid  = mem_valid_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_final_pcpi_accel.sv
// Directed bench for final_pcpi_accel: instruction table, memory responder with access log,
// plus hand-written non-match and mid-operation reset sequences.
module tb_final_pcpi_accel;

  logic        clk, resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;
  logic        mem_valid, mem_write, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  final_pcpi_accel #(.NUM_PIXELS(3)) dut (
    .clk(clk), .resetn(resetn),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  typedef struct {
    logic [31:0]      insn;
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [31:0]      exp_rd;
    int               exp_cyc;
    logic [2:0][7:0]  gray;
  } vec_t;

  logic [31:0] mem [logic [31:0]];
  acc_t        log_q[$];
  int          checks = 0;
  int          failures = 0;
  int          proto_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: mem_ready one cycle after the request, one outstanding access at most.
  initial begin
    logic        pend;
    logic        pend_we;
    logic [31:0] pend_addr, pend_wdata;
    pend = 1'b0; pend_we = 1'b0; pend_addr = '0; pend_wdata = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        pend = 1'b0;
        mem_ready = 1'b0;
      end else begin
        mem_ready = 1'b0;
        if (pend) begin
          if (mem_valid === 1'b1) proto_err++;
          if (mem_addr !== pend_addr || mem_write !== pend_we || (pend_we && mem_wdata !== pend_wdata))
            proto_err++;
          if (pend_we) mem[pend_addr] = pend_wdata;
          else mem_rdata = mem.exists(pend_addr) ? mem[pend_addr] : 32'd0;
          mem_ready = 1'b1;
          pend = 1'b0;
        end else if (mem_valid === 1'b1) begin
          log_q.push_back('{mem_write, mem_addr, mem_wdata});
          pend = 1'b1;
          pend_we = mem_write;
          pend_addr = mem_addr;
          pend_wdata = mem_wdata;
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    int          cyc;
    logic        got, wait2;
    logic        is_gray;
    int          exp_n, n, p, s;
    logic        ewe;
    logic [31:0] eaddr, edata;
    log_q.delete();
    @(posedge clk); #1;
    pcpi_insn = v.insn; pcpi_rs1 = v.rs1; pcpi_rs2 = v.rs2; pcpi_valid = 1'b1;
    cyc = 1; got = 1'b0; wait2 = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2) wait2 = pcpi_wait;
      if (pcpi_ready) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_ready_seen"}, 32'(got), 32'd1);
    check({tag, "_rd"}, pcpi_rd, v.exp_rd);
    check({tag, "_cycles"}, 32'(cyc), 32'(v.exp_cyc));
    check({tag, "_wr_with_ready"}, 32'(pcpi_wr), 32'd1);
    check({tag, "_wait_at_ready"}, 32'(pcpi_wait), 32'd0);
    check({tag, "_wait_after_accept"}, 32'(wait2), 32'(v.exp_cyc > 2));
    @(posedge clk); #1;
    check({tag, "_ready_one_cycle"}, 32'({pcpi_ready, pcpi_wr}), 32'd0);
    @(posedge clk); #1;
    pcpi_valid = 1'b0;
    check({tag, "_no_reaccept"}, 32'({pcpi_wait, mem_valid}), 32'd0);
    @(posedge clk); #1;

    is_gray = (v.insn[14:12] == 3'b000);
    exp_n = is_gray ? 12 : int'(v.rs2);
    n = log_q.size();
    check({tag, "_access_count"}, 32'(n), 32'(exp_n));
    for (int k = 0; k < n && k < exp_n; k++) begin
      p = k / 4;
      s = k % 4;
      edata = '0;
      if (!is_gray) begin
        ewe = 1'b0;
        eaddr = v.rs1 + 32'(4 * k);
      end else if (s < 3) begin
        ewe = 1'b0;
        eaddr = v.rs1 + 32'(12 * p + 4 * s);
      end else begin
        ewe = 1'b1;
        eaddr = v.rs2 + 32'(4 * p);
        edata = {24'd0, v.gray[p]};
      end
      check($sformatf("%s_acc%0d_we", tag, k), 32'(log_q[k].we), 32'(ewe));
      check($sformatf("%s_acc%0d_addr", tag, k), log_q[k].addr, eaddr);
      if (ewe) check($sformatf("%s_acc%0d_data", tag, k), log_q[k].data, edata);
    end
  endtask

  initial begin
    vec_t        vecs[5];
    vec_t        v;
    logic [31:0] bad_insn[2];
    logic        bad, hit;
    int          nreq;

    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[5];
    vec_t        v;
    logic [31:0] bad_insn[2];
    logic        bad, hit;
    int          nreq;

    resetn = 1'b0; pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;

    mem[32'h10000] = 32'd255; mem[32'h10004] = 32'd255; mem[32'h10008] = 32'd255;
    mem[32'h1000C] = 32'd100; mem[32'h10010] = 32'd50;  mem[32'h10014] = 32'd200;
    mem[32'h10018] = 32'd0;   mem[32'h1001C] = 32'd0;   mem[32'h10020] = 32'd0;
    mem[32'h100] = 32'd1; mem[32'h104] = 32'd2; mem[32'h108] = 32'd3; mem[32'h10C] = 32'd4;
    mem[32'h200] = 32'hFFFFFFFF; mem[32'h204] = 32'd2;
    mem[32'h30000] = 32'hFFFFFF10; mem[32'h30004] = 32'h20;       mem[32'h30008] = 32'h30;
    mem[32'h3000C] = 32'h12345600; mem[32'h30010] = 32'hDEAD00FF; mem[32'h30014] = 32'h0;
    mem[32'h30018] = 32'h80;       mem[32'h3001C] = 32'h80;       mem[32'h30020] = 32'h80;

    vecs[0] = '{32'h0000000B, 32'h00010000, 32'h00020000, 32'd3,  26, {8'd0,   8'd82,  8'd255}};
    vecs[1] = '{32'h0000100B, 32'h00000100, 32'd4,        32'd10, 10, 24'd0};
    vecs[2] = '{32'h0000100B, 32'h00000200, 32'd2,        32'd1,  6,  24'd0};
    vecs[3] = '{32'h0000100B, 32'h00000100, 32'd0,        32'd0,  2,  24'd0};
    vecs[4] = '{32'h0000000B, 32'h00030000, 32'h00040000, 32'd3,  26, {8'd128, 8'd149, 8'd29}};
    bad_insn[0] = 32'h02000033;
    bad_insn[1] = 32'h0000200B;

    repeat (3) @(posedge clk);
    #1;
    check("reset_pcpi", 32'({pcpi_wr, pcpi_wait, pcpi_ready}), 32'd0);
    check("reset_pcpi_rd", pcpi_rd, 32'd0);
    check("reset_mem_ctl", 32'({mem_valid, mem_write}), 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 2; i++) begin
      log_q.delete();
      @(posedge clk); #1;
      pcpi_insn = bad_insn[i]; pcpi_rs1 = 32'h10000; pcpi_rs2 = 32'd4; pcpi_valid = 1'b1;
      bad = 1'b0;
      repeat (20) begin
        @(posedge clk); #1;
        if (pcpi_wait || pcpi_ready || pcpi_wr || mem_valid) bad = 1'b1;
      end
      pcpi_valid = 1'b0;
      check($sformatf("nomatch%0d_ignored", i), 32'(bad), 32'd0);
      check($sformatf("nomatch%0d_no_access", i), 32'(log_q.size()), 32'd0);
    end

    // Reset while the G read of the first pixel is outstanding.
    @(posedge clk); #1;
    pcpi_insn = 32'h0000000B; pcpi_rs1 = 32'h10000; pcpi_rs2 = 32'h50000; pcpi_valid = 1'b1;
    nreq = 0; hit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (mem_valid) nreq++;
      if (nreq == 2) begin
        hit = 1'b1;
        break;
      end
    end
    check("rst_reached_rd_g", 32'(hit), 32'd1);
    resetn = 1'b0;
    pcpi_valid = 1'b0;
    #1;
    check("rst_pcpi", 32'({pcpi_wr, pcpi_wait, pcpi_ready}), 32'd0);
    check("rst_pcpi_rd", pcpi_rd, 32'd0);
    check("rst_mem_ctl", 32'({mem_valid, mem_write}), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    log_q.delete();
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_access", 32'(log_q.size()), 32'd0);
    check("rst_no_write", 32'(mem.exists(32'h50000)), 32'd0);

    v = vecs[0];
    v.rs2 = 32'h00060000;
    run_vec(v, "post_rst");

    check("mem_protocol_errors", 32'(proto_err), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/final_pcpi_accel.md
Name: final_pcpi_accel

Overview:
- PCPI coprocessor attached to the picorv32 core.
- Executes custom-0 instructions that process image data in shared memory through a private single-word memory master port.
- The primary operation converts an interleaved RGB image (one byte per 32-bit word; default 120x120 pixels at byte address 0x10000) to 8-bit grayscale.
- A secondary word-sum operation supports firmware checks.

Parameters:
- NUM_PIXELS, 14400, pixels processed by one GRAY instruction.

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- pcpi_valid  in  1  core presents an instruction
- pcpi_insn  in  32  instruction word
- pcpi_rs1  in  32  rs1 value
- pcpi_rs2  in  32  rs2 value
- pcpi_wr  out  1  write pcpi_rd to rd (pulsed with pcpi_ready)
- pcpi_rd  out  32  result value
- pcpi_wait  out  1  busy; suppresses the core's 16-cycle PCPI timeout
- pcpi_ready  out  1  one-cycle completion strobe
- mem_valid  out  1  one-cycle memory request
- mem_write  out  1  1 = write, 0 = read
- mem_addr  out  32  byte address, word aligned
- mem_wdata  out  32  write data
- mem_ready  in  1  access complete; arrives the cycle after mem_valid
- mem_rdata  in  32  read data, valid while mem_ready=1

Behaviour:
- Decode: the instruction matches when insn[6:0]=7'b0001011 and insn[31:25]=0.
  - funct3 insn[14:12]=000 selects GRAY; 001 selects SUM.
  - Other encodings are ignored: no wait, no ready; the core handles them as illegal.
- Reset (async, resetn=0): all outputs 0, mem_addr=0, state IDLE, accumulators 0. Assertion mid-operation aborts immediately with no further memory requests.
- States: IDLE, RD_R, RD_G, RD_B, WR, SUM_RD, RESP, COOL.
- IDLE:
  - On pcpi_valid && match, latch rs1/rs2/op, clear the index, and assert pcpi_wait from the next cycle until the RESP cycle.
  - GRAY goes to RD_R, or to RESP if NUM_PIXELS=0.
  - SUM goes to SUM_RD, or to RESP if rs2=0.
- Memory access rule:
  - In each memory state, mem_valid is high for exactly one cycle (the state's first cycle).
  - The FSM then holds with mem_valid=0 until mem_ready=1, and captures mem_rdata on that edge.
  - Minimum 2 cycles per access.
  - mem_addr and mem_wdata stay stable from the request until ready; never two outstanding requests.
- GRAY, pixel i = 0..NUM_PIXELS-1:
  - RD_R reads rs1+12i, RD_G reads rs1+12i+4, RD_B reads rs1+12i+8; use bits [7:0] of each.
  - WR writes rs2+4i with data {24'b0, gray}.
  - gray = (77*R + 150*G + 29*B) >> 8, 16-bit intermediate, result 8 bits, no rounding.
  - After WR, i+1 < NUM_PIXELS returns to RD_R; otherwise go to RESP.
  - Result = NUM_PIXELS.
- SUM:
  - SUM_RD reads rs1+4i for i = 0..rs2-1 and accumulates full 32-bit words, wrapping mod 2^32.
  - Result = sum.
- RESP (one cycle): pcpi_ready=1, pcpi_wr=1, pcpi_rd=result, pcpi_wait=0. Next state COOL.
- COOL (one cycle): pcpi_valid is ignored so the same instruction is not re-accepted. Next state IDLE.
- pcpi_rd is held at the last result outside RESP; the core only samples it with ready.
- Address arithmetic is 32-bit, wrapping. The block never drives an address beyond the computed range; idle mem_addr keeps its last value (0 after reset).
- Latency: GRAY = 8*NUM_PIXELS + 2 cycles from acceptance to ready, with 1-cycle memory latency. SUM = 2*rs2 + 2.

Test Plan:
- GRAY, NUM_PIXELS=3, rs1=0x10000, src words (255,255,255),(100,50,200),(0,0,0), rs2=0x20000 -> memory 0x20000=255, 0x20004=82, 0x20008=0; rd=3; exactly 9 reads + 3 writes in R,G,B,W order.
- GRAY with src words carrying junk upper bits (R=0xFFFFFF10, G=0x20, B=0x30) -> only low bytes used: gray=(1232+4800+1392)>>8=29.
- SUM rs1=0x100, words 1,2,3,4, rs2=4 -> rd=10, pcpi_wr=1 one cycle, total 10 cycles; SUM of 0xFFFFFFFF and 2 -> rd=1 (wrap).
- SUM with rs2=0 -> ready 2 cycles after acceptance, rd=0, no mem_valid.
- Non-matching insn (opcode 0110011, funct7=1) with pcpi_valid held 20 cycles -> pcpi_wait, pcpi_ready and mem_valid stay 0.
- resetn pulled low during RD_G of a GRAY -> all outputs 0 immediately, no further writes; a new GRAY after release completes normally.
